// File: rtl/l2_mem_adapter_pkg.sv
// Shared types for the L2-to-memory adapter: bus-visible status and adapter FSM encoding.
package l2_mem_adapter_pkg;

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  typedef logic [2:0] l2_adapter_state_t;

  localparam l2_adapter_state_t IDLE    = 3'd0;
  localparam l2_adapter_state_t WR      = 3'd1;
  localparam l2_adapter_state_t RD_REQ  = 3'd2;
  localparam l2_adapter_state_t RD_WAIT = 3'd3;
  localparam l2_adapter_state_t RD_DONE = 3'd4;
  localparam l2_adapter_state_t DRAIN   = 3'd5;
  localparam l2_adapter_state_t ERR     = 3'd6;

endpackage

// File: rtl/l2_wbuf_fifo.sv
// Posted write buffer: synchronous FIFO with flush; head is the oldest entry.
module l2_wbuf_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic         last,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   cnt;

  // Pointers wrap naturally; cnt is one bit wider to tell full from empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign last  = (cnt == (PW+1)'(1));
  assign head  = mem[rptr];

endmodule

// File: rtl/l2_mem_adapter.sv
// Bridges the bus controller's L2 port to a single-outstanding memory port.
// Writes are posted through a small FIFO; reads wait for the FIFO to drain.
module l2_mem_adapter
  import l2_mem_adapter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              l2REN,
  input  logic              l2WEN,
  input  logic [ADDR_W-1:0] l2addr,
  input  logic [DATA_W-1:0] l2store,
  output logic [DATA_W-1:0] l2load,
  output logic [1:0]        l2state,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  l2_adapter_state_t          fsm, fsm_nxt;
  logic [TW-1:0]              tcnt;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       wr_acc, pop, flush, full, empty, last, in_rd, tmo, rd_take;
  logic [ADDR_W+DATA_W-1:0]   head;
  l2_state_t                  st;

  assign wr_acc = l2WEN && !full && (fsm != ERR);
  assign pop    = (fsm == WR) && mem_ready;
  assign flush  = pop && mem_err;
  assign in_rd  = (fsm == RD_REQ) || (fsm == RD_WAIT);
  // Fires on the TIMEOUT-th cycle spent waiting, so the error shows TIMEOUT cycles after RD_REQ entry.
  assign tmo    = in_rd && (tcnt == TW'(TIMEOUT - 1));
  assign rd_take = l2REN && mem_rvalid &&
                   ((fsm == RD_WAIT) || ((fsm == RD_REQ) && mem_ready));

  l2_wbuf_fifo #(.W(ADDR_W + DATA_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (wr_acc),
    .pop   (pop),
    .flush (flush),
    .din   ({l2addr, l2store}),
    .full  (full),
    .empty (empty),
    .last  (last),
    .head  (head)
  );

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (!empty) fsm_nxt = WR;
               else if (l2REN && !l2WEN) fsm_nxt = RD_REQ;
      WR:      if (mem_ready) begin
                 if (mem_err) fsm_nxt = ERR;
                 else if (last && !wr_acc) fsm_nxt = IDLE;
               end
      // A dropped l2REN with data arriving in the same cycle just discards it.
      RD_REQ:  if (mem_ready && mem_rvalid) fsm_nxt = !l2REN ? IDLE : (mem_err ? ERR : RD_DONE);
               else if (mem_ready) fsm_nxt = l2REN ? RD_WAIT : DRAIN;
               else if (tmo) fsm_nxt = ERR;
      RD_WAIT: if (mem_rvalid) fsm_nxt = !l2REN ? IDLE : (mem_err ? ERR : RD_DONE);
               else if (tmo) fsm_nxt = ERR;
               else if (!l2REN) fsm_nxt = DRAIN;
      RD_DONE: fsm_nxt = IDLE;
      DRAIN:   if (mem_rvalid) fsm_nxt = IDLE;
      ERR:     if (!l2REN && !l2WEN) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fsm     <= IDLE;
      tcnt    <= '0;
      rd_addr <= '0;
      l2load  <= '0;
    end else begin
      fsm  <= fsm_nxt;
      tcnt <= in_rd ? tcnt + 1'b1 : '0;
      if ((fsm == IDLE) && (fsm_nxt == RD_REQ)) rd_addr <= l2addr;
      if (rd_take) l2load <= mem_rdata;
    end
  end

  assign mem_req   = (fsm == WR) || (fsm == RD_REQ);
  assign mem_wen   = (fsm == WR);
  assign mem_addr  = (fsm == WR) ? head[ADDR_W+DATA_W-1:DATA_W] : rd_addr;
  assign mem_wdata = (fsm == WR) ? head[DATA_W-1:0] : '0;

  always_comb begin
    if (fsm == ERR)
      st = L2_ERROR;
    else if (wr_acc || (fsm == RD_DONE))
      st = L2_ACCESS;
    else if (in_rd || (fsm == DRAIN) || (l2REN && !empty) || (l2WEN && full))
      st = L2_BUSY;
    else
      st = L2_FREE;
  end

  assign l2state = st;

endmodule

// File: tb/tb_l2_mem_adapter.sv
// Directed scenarios plus a randomized write/read mix checked against a memory-level model.
module tb_l2_mem_adapter;
  import l2_mem_adapter_pkg::*;

  localparam int AW = 32, DW = 32, DEPTH = 4, TMO = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          l2REN, l2WEN;
  logic [AW-1:0] l2addr;
  logic [DW-1:0] l2store, l2load;
  logic [1:0]    l2state;
  logic          mem_req, mem_wen, mem_ready, mem_rvalid, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  l2_mem_adapter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .l2REN(l2REN), .l2WEN(l2WEN), .l2addr(l2addr), .l2store(l2store),
    .l2load(l2load), .l2state(l2state), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int n_tot = 0, n_bad = 0, cyc = 0;
  bit mem_hold = 0, lat_rand = 0, rv_block = 0, rv_inject = 0, rv_pend = 0;
  int rdy_cd = 0, rv_cd = 0, rv_lat = 0;
  int n_acc = 0, n_pop = 0, last_wr_cyc = 0, first_rd_cyc = -1;
  logic [DW-1:0] rv_data, last_load;
  logic [DW-1:0] mstore [logic [AW-1:0]];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  logic [AW+DW-1:0] memq[$], expq[$];

  function automatic logic [DW-1:0] mdef(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory responder: optional ready latency, read data a programmable number of cycles after accept.
  task automatic mem_drive();
    mem_ready = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
    if (rv_inject) begin mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D; end
    if (rv_pend) begin
      if (rv_cd == 0) begin mem_rvalid = 1; mem_rdata = rv_data; rv_pend = 0; end
      else rv_cd--;
    end
    if (mem_req && !mem_hold) begin
      if (!mem_wen && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (rdy_cd == 0) begin
        mem_ready = 1;
        if (mem_wen) begin
          memq.push_back({mem_addr, mem_wdata});
          mstore[mem_addr] = mem_wdata;
          n_pop++;
          last_wr_cyc = cyc;
        end else begin
          chk("rd_order", n_acc - n_pop, 0);
          if (!rv_block) begin
            rv_pend = 1;
            rv_cd   = lat_rand ? int'($urandom_range(0, 1)) : rv_lat;
            rv_data = mstore.exists(mem_addr) ? mstore[mem_addr] : mdef(mem_addr);
          end
        end
        rdy_cd = lat_rand ? int'($urandom_range(0, 2)) : 0;
      end else rdy_cd--;
    end
  endtask

  task automatic step(input logic ren, input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    l2REN = ren; l2WEN = wen; l2addr = a; l2store = d;
    mem_drive();
    #1;
    cyc++;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, e;
    int occ;
    bit got, acc;

    nRST = 0; l2REN = 0; l2WEN = 0; l2addr = '0; l2store = '0;
    mem_ready = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_state", l2state, L2_FREE);
    chk("rst_mem", {mem_req, mem_wen, mem_addr, mem_wdata}, '0);
    chk("rst_load", l2load, '0);
    @(negedge CLK); nRST = 1;

    // 1: single read, zero-wait memory
    mstore[32'h100] = 32'hDEADBEEF; shadow[32'h100] = 32'hDEADBEEF;
    step(1, 0, 32'h100, 0); chk("t1_c0", l2state, L2_FREE);
    step(1, 0, 32'h100, 0); chk("t1_c1_req", {mem_req, mem_wen, mem_addr}, {2'b10, 32'h100});
    chk("t1_c1_st", l2state, L2_BUSY);
    step(1, 0, 32'h100, 0); chk("t1_c2_st", l2state, L2_BUSY);
    step(1, 0, 32'h100, 0); chk("t1_c3_st", l2state, L2_ACCESS);
    chk("t1_c3_load", l2load, 32'hDEADBEEF);
    last_load = 32'hDEADBEEF;
    step(0, 0, 0, 0); chk("t1_c4_st", l2state, L2_FREE);

    // 2: fill the buffer with memory stalled, then release
    mem_hold = 1; memq.delete();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h200 + 4 * i, 32'hA000_0000 + i);
      chk("t2_acc", l2state, L2_ACCESS);
      n_acc++;
    end
    step(0, 1, 32'h210, 32'hA000_0004); chk("t2_full", l2state, L2_BUSY);
    chk("t2_head", {mem_req, mem_wen, mem_addr}, {2'b11, 32'h200});
    mem_hold = 0;
    for (int k = 0; k < 12 && memq.size() < 4; k++) step(0, 0, 0, 0);
    chk("t2_nwr", memq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (i < memq.size()) ? memq[i] : '0, {32'h200 + 4 * i, 32'hA000_0000 + i});
    repeat (3) step(0, 0, 0, 0);
    chk("t2_nwr_final", memq.size(), 4);
    chk("t2_idle", mem_req, 0);

    // 3: read behind a buffered write to the same address
    step(0, 1, 32'h300, 32'hCAFE_0003); chk("t3_wacc", l2state, L2_ACCESS);
    n_acc++; shadow[32'h300] = 32'hCAFE_0003;
    mem_hold = 1; first_rd_cyc = -1;
    for (int k = 0; k < 5; k++) begin step(1, 0, 32'h300, 0); chk("t3_busy", l2state, L2_BUSY); end
    mem_hold = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1, 0, 32'h300, 0);
      if (l2state == L2_ACCESS) begin got = 1; chk("t3_load", l2load, 32'hCAFE_0003); end
    end
    chk("t3_done", got, 1);
    chk("t3_order", first_rd_cyc > last_wr_cyc, 1);
    last_load = 32'hCAFE_0003;
    step(0, 0, 0, 0);

    // 4: read timeout, error hold, late rvalid
    rv_block = 1;
    step(1, 0, 32'h400, 0);
    for (int k = 1; k <= TMO; k++) begin step(1, 0, 32'h400, 0); chk("t4_busy", l2state, L2_BUSY); end
    step(1, 0, 32'h400, 0); chk("t4_err", l2state, L2_ERROR);
    repeat (3) begin step(1, 0, 32'h400, 0); chk("t4_hold", {l2state, mem_req}, {L2_ERROR, 1'b0}); end
    step(0, 0, 0, 0); chk("t4_drop", l2state, L2_ERROR);
    step(0, 0, 0, 0); chk("t4_free", l2state, L2_FREE);
    rv_block = 0; rv_inject = 1;
    step(0, 0, 0, 0); rv_inject = 0; chk("t4_late", l2state, L2_FREE);
    step(0, 0, 0, 0); chk("t4_late2", l2state, L2_FREE);
    chk("t4_load", l2load, last_load);

    // 5: abort in RD_WAIT
    rv_lat = 3;
    step(1, 0, 32'h500, 0);
    step(1, 0, 32'h500, 0);
    step(1, 0, 32'h500, 0); chk("t5_wait", l2state, L2_BUSY);
    step(0, 0, 0, 0); chk("t5_abort", l2state, L2_BUSY);
    step(0, 0, 0, 0); chk("t5_drain", l2state, L2_BUSY);
    step(0, 0, 0, 0); chk("t5_rv", l2state, L2_BUSY);
    step(0, 0, 0, 0); chk("t5_free", l2state, L2_FREE);
    chk("t5_load", l2load, last_load);
    rv_lat = 0;

    // 6: async reset with two entries queued
    mem_hold = 1; memq.delete();
    step(0, 1, 32'h600, 32'h6600_0000); chk("t6_acc0", l2state, L2_ACCESS);
    step(0, 1, 32'h604, 32'h6600_0001); chk("t6_acc1", l2state, L2_ACCESS);
    step(0, 1, 32'h608, 32'h6600_0002); chk("t6_req", {mem_req, mem_wen}, 2'b11);
    l2WEN = 0; nRST = 0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_st", l2state, L2_FREE);
    @(negedge CLK); nRST = 1;
    rv_pend = 0; rdy_cd = 0; n_acc = n_pop;
    step(0, 0, 0, 0); chk("t6_post", {l2state, mem_req}, {L2_FREE, 1'b0});
    mem_hold = 0;
    repeat (4) step(0, 0, 0, 0);
    chk("t6_nowr", memq.size(), 0);

    // Randomized mix against a word-addressed memory model
    lat_rand = 1; memq.delete(); expq.delete();
    for (int op = 0; op < 80; op++) begin
      if ($urandom_range(0, 9) < 6) begin
        for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
          a = 32'h1000 + 4 * $urandom_range(0, 7); d = $urandom; acc = 0;
          for (int t = 0; t < 40 && !acc; t++) begin
            occ = n_acc - n_pop;
            step(0, 1, a, d);
            chk("rw_state", l2state, (occ < DEPTH) ? L2_ACCESS : L2_BUSY);
            if (occ < DEPTH) begin acc = 1; n_acc++; shadow[a] = d; expq.push_back({a, d}); end
          end
        end
      end else begin
        a = 32'h1000 + 4 * $urandom_range(0, 7);
        e = shadow.exists(a) ? shadow[a] : mdef(a);
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
          step(1, 0, a, 0);
          if (l2state == L2_ACCESS) begin got = 1; chk("rr_data", l2load, e); end
        end
        chk("rr_done", got, 1);
      end
      repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
    end
    for (int t = 0; t < 60 && n_pop < n_acc; t++) step(0, 0, 0, 0);
    chk("rw_count", memq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk("rw_order", (i < memq.size()) ? memq[i] : '0, expq[i]);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
